// File: rtl/usb_tx_scheduler.sv
// USB TX scheduler: buffers ADC sample bytes in a small FIFO and emits
// fixed-length frames (sync, sequence, data) toward the FT245R writer.
// Status messages are interleaved between frames only.
module usb_tx_scheduler #(
   parameter int         FIFO_DEPTH = 16,
   parameter int         FRAME_LEN  = 64,
   parameter logic [7:0] SYNC_DATA  = 8'hA5,
   parameter logic [7:0] SYNC_STAT  = 8'h5A
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic                          enable,
   input  logic                          adcstrobe,
   input  logic [7:0]                    adcval,
   input  logic                          stat_req,
   input  logic [7:0]                    stat_byte,
   output logic                          stat_ack,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [7:0]                    drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [8:0] LAST_BEAT = 9'(FRAME_LEN - 1);

   typedef enum logic [2:0] {IDLE, STAT0, STAT1, HDR0, HDR1, DATA} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rdPtr_q, wrPtr_q, rdPtrNext;
   logic [CW-1:0] count_q, count_d, countAfterRd;
   logic [7:0]    seq_q, seq_d;
   logic [7:0]    statByte_q, statByte_d;
   logic [7:0]    drop_q, drop_d;
   logic [7:0]    txData_q, txData_d;
   logic          txValid_q, txValid_d;
   logic          pad_q, pad_d;
   logic          statAck_q, statAck_d;
   logic [8:0]    beat_q, beat_d;
   logic          xfer, rdEn, wrReq, wrEn, dropEn, fifoFull;
   logic [7:0]    headNext;
   logic          dataValid, dataPad;
   logic [7:0]    dataByte;

   assign xfer         = txValid_q & tx_ready;
   assign rdEn         = (state_q == DATA) & xfer & ~pad_q;
   assign fifoFull     = (count_q == CW'(FIFO_DEPTH));
   assign wrReq        = adcstrobe & enable;
   assign wrEn         = wrReq & (~fifoFull | rdEn);
   assign dropEn       = wrReq & fifoFull & ~rdEn;
   assign rdPtrNext    = rdPtr_q + AW'(rdEn);
   assign countAfterRd = count_q - CW'(rdEn);
   assign count_d      = countAfterRd + CW'(wrEn);
   assign headNext     = (countAfterRd == '0) ? adcval : mem_q[rdPtrNext];
   assign drop_d       = (dropEn && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

   assign stat_ack   = statAck_q;
   assign tx_data    = txData_q;
   assign tx_valid   = txValid_q;
   assign drop_cnt   = drop_q;
   assign fifo_level = count_q;

   // Sample FIFO storage, pointers, occupancy and the saturating drop counter.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         if (wrEn) begin
            mem_q[wrPtr_q] <= adcval;
            wrPtr_q        <= wrPtr_q + AW'(1);
         end
         rdPtr_q <= rdPtrNext;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   // Byte to present in DATA next cycle: FIFO head (seeing through a same-cycle write into an empty FIFO), else pad once enable is gone.
   always_comb begin
      dataValid = 1'b0;
      dataByte  = 8'h00;
      dataPad   = 1'b0;
      if (count_d != '0) begin
         dataValid = 1'b1;
         dataByte  = headNext;
      end else if (!enable) begin
         dataValid = 1'b1;
         dataPad   = 1'b1;
      end
   end

   // State and registered output flops.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= IDLE;
         txValid_q  <= 1'b0;
         txData_q   <= '0;
         pad_q      <= 1'b0;
         statAck_q  <= 1'b0;
         statByte_q <= '0;
         seq_q      <= '0;
         beat_q     <= '0;
      end else begin
         state_q    <= state_d;
         txValid_q  <= txValid_d;
         txData_q   <= txData_d;
         pad_q      <= pad_d;
         statAck_q  <= statAck_d;
         statByte_q <= statByte_d;
         seq_q      <= seq_d;
         beat_q     <= beat_d;
      end
   end

   // Next state and next output byte; a stalled byte holds because nothing changes without a transfer.
   always_comb begin
      state_d    = state_q;
      txValid_d  = txValid_q;
      txData_d   = txData_q;
      pad_d      = pad_q;
      statAck_d  = 1'b0;
      statByte_d = statByte_q;
      seq_d      = seq_q;
      beat_d     = beat_q;
      case (state_q)
         IDLE: begin
            txValid_d = 1'b0;
            txData_d  = 8'h00;
            pad_d     = 1'b0;
            if (stat_req) begin
               statAck_d  = 1'b1;
               statByte_d = stat_byte;
               state_d    = STAT0;
               txValid_d  = 1'b1;
               txData_d   = SYNC_STAT;
            end else if (count_q != '0 && enable) begin
               state_d   = HDR0;
               txValid_d = 1'b1;
               txData_d  = SYNC_DATA;
            end
         end
         STAT0: begin
            if (xfer) begin
               state_d  = STAT1;
               txData_d = statByte_q;
            end
         end
         STAT1: begin
            if (xfer) begin
               state_d   = IDLE;
               txValid_d = 1'b0;
               txData_d  = 8'h00;
            end
         end
         HDR0: begin
            if (xfer) begin
               state_d  = HDR1;
               txData_d = seq_q;
            end
         end
         HDR1: begin
            if (xfer) begin
               state_d   = DATA;
               beat_d    = '0;
               txValid_d = dataValid;
               txData_d  = dataByte;
               pad_d     = dataPad;
            end
         end
         DATA: begin
            if (xfer) begin
               beat_d = beat_q + 9'd1;
               if (beat_q == LAST_BEAT) begin
                  state_d   = IDLE;
                  seq_d     = seq_q + 8'd1;
                  beat_d    = '0;
                  txValid_d = 1'b0;
                  txData_d  = 8'h00;
                  pad_d     = 1'b0;
               end else begin
                  txValid_d = dataValid;
                  txData_d  = dataByte;
                  pad_d     = dataPad;
               end
            end else if (!txValid_q) begin
               txValid_d = dataValid;
               txData_d  = dataByte;
               pad_d     = dataPad;
            end
         end
         default: begin
            state_d   = IDLE;
            txValid_d = 1'b0;
            txData_d  = 8'h00;
            pad_d     = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler (FIFO_DEPTH=16, FRAME_LEN=4).
// Stimulus pushes the expected byte stream; a negedge monitor pops and compares every transfer.
module tb_usb_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       enable = 1'b0;
   logic       adcstrobe = 1'b0;
   logic [7:0] adcval = 8'h00;
   logic       stat_req = 1'b0;
   logic [7:0] stat_byte = 8'h00;
   logic       stat_ack;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] drop_cnt;
   logic [4:0] fifo_level;

   int         checks = 0;
   int         fails = 0;
   logic [7:0] expQ[$];
   logic       prevStall = 1'b0;
   logic [7:0] prevData = 8'h00;

   usb_tx_scheduler #(
      .FIFO_DEPTH(16),
      .FRAME_LEN (4),
      .SYNC_DATA (8'hA5),
      .SYNC_STAT (8'h5A)
   ) dut (
      .clk       (clk),
      .rst_      (rst_),
      .enable    (enable),
      .adcstrobe (adcstrobe),
      .adcval    (adcval),
      .stat_req  (stat_req),
      .stat_byte (stat_byte),
      .stat_ack  (stat_ack),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .drop_cnt  (drop_cnt),
      .fifo_level(fifo_level)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle sample strobe, entered and left just after a rising edge.
   task automatic applyStimulus(input logic [7:0] val);
      adcstrobe = 1'b1;
      adcval    = val;
      tick();
      adcstrobe = 1'b0;
   endtask

   task automatic pushFrame(input logic [7:0] seq, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      expQ.push_back(8'hA5);
      expQ.push_back(seq);
      expQ.push_back(b0);
      expQ.push_back(b1);
      expQ.push_back(b2);
      expQ.push_back(b3);
   endtask

   task automatic waitDrain(input int maxCycles, input string name);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput(name, expQ.size(), 0);
      tick();
   endtask

   // Monitor: compares each transferred byte with the scoreboard and checks stalled bytes hold.
   always @(negedge clk) begin
      if (!rst_) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("holdValid", tx_valid, 1);
            checkOutput("holdData", tx_data, prevData);
         end
         if (tx_valid && tx_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpectedByte: got %0h, expected no transfer at %0t", tx_data, $time);
            end else begin
               checkOutput("txByte", tx_data, expQ.pop_front());
            end
         end
         prevStall = tx_valid && !tx_ready;
         prevData  = tx_data;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int ackCount;

      // Reset values while reset is held.
      #23;
      checkOutput("rstValid", tx_valid, 0);
      checkOutput("rstData", tx_data, 0);
      checkOutput("rstAck", stat_ack, 0);
      checkOutput("rstDrop", drop_cnt, 0);
      checkOutput("rstLevel", fifo_level, 0);
      tick();
      rst_ = 1'b1;
      tick();

      // Basic frame with latency checks.
      $display("[TB] basic frame");
      enable = 1'b1;
      tx_ready = 1'b1;
      pushFrame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
      applyStimulus(8'h11);
      checkOutput("latLevel", fifo_level, 1);
      checkOutput("latIdleValid", tx_valid, 0);
      applyStimulus(8'h22);
      checkOutput("latHdrValid", tx_valid, 1);
      checkOutput("latHdrData", tx_data, 8'hA5);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      waitDrain(40, "frame1Drain");
      repeat (3) tick();
      checkOutput("idleAfterFrame", tx_valid, 0);

      // Back-pressure in HDR1 and in DATA.
      $display("[TB] back-pressure");
      tx_ready = 1'b0;
      pushFrame(8'h01, 8'h55, 8'h66, 8'h77, 8'h88);
      applyStimulus(8'h55);
      applyStimulus(8'h66);
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      repeat (5) tick();
      checkOutput("hdr1Hold", tx_data, 8'h01);
      tx_ready = 1'b1;
      tick();
      tick();
      tx_ready = 1'b0;
      repeat (5) tick();
      checkOutput("dataHold", tx_data, 8'h66);
      tx_ready = 1'b1;
      waitDrain(40, "frame2Drain");

      // Overflow with writer stalled, then write-while-read at full.
      $display("[TB] overflow");
      tx_ready = 1'b0;
      pushFrame(8'h02, 8'h30, 8'h31, 8'h32, 8'h33);
      pushFrame(8'h03, 8'h34, 8'h35, 8'h36, 8'h37);
      pushFrame(8'h04, 8'h38, 8'h39, 8'h3A, 8'h3B);
      pushFrame(8'h05, 8'h3C, 8'h3D, 8'h3E, 8'h3F);
      pushFrame(8'h06, 8'hE0, 8'hE1, 8'h00, 8'h00);
      for (int i = 0; i < 20; i++) applyStimulus(8'(8'h30 + i));
      checkOutput("fullLevel", fifo_level, 16);
      checkOutput("dropCount", drop_cnt, 4);
      tx_ready = 1'b1;
      n = 0;
      while (!(tx_valid && tx_data == 8'h30) && n < 20) begin
         tick();
         n++;
      end
      checkOutput("reachData", (tx_valid && tx_data == 8'h30), 1);
      applyStimulus(8'hE0);
      checkOutput("fullRwLevel", fifo_level, 16);
      checkOutput("fullRwDrop", drop_cnt, 4);
      n = 0;
      while (fifo_level > 2 && n < 100) begin
         tick();
         n++;
      end
      applyStimulus(8'hE1);
      n = 0;
      while (!(fifo_level == 0 && !tx_valid) && n < 100) begin
         tick();
         n++;
      end
      checkOutput("fifoEmptied", fifo_level, 0);

      // Enable drops with the FIFO empty mid-frame: pad bytes finish it.
      $display("[TB] padding");
      enable = 1'b0;
      waitDrain(40, "padDrain");
      repeat (5) tick();
      checkOutput("noNewFrame", tx_valid, 0);

      // Status request raised mid-frame.
      $display("[TB] status interleave");
      enable = 1'b1;
      pushFrame(8'h07, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
      expQ.push_back(8'h5A);
      expQ.push_back(8'hC3);
      applyStimulus(8'hD0);
      applyStimulus(8'hD1);
      applyStimulus(8'hD2);
      applyStimulus(8'hD3);
      checkOutput("midFrameData", tx_data, 8'hD0);
      stat_byte = 8'hC3;
      stat_req  = 1'b1;
      ackCount  = 0;
      n = 0;
      while ((expQ.size() != 0 || n < 3) && n < 60) begin
         tick();
         if (stat_ack) begin
            ackCount++;
            stat_req = 1'b0;
         end
         n++;
      end
      repeat (3) begin
         tick();
         if (stat_ack) ackCount++;
      end
      checkOutput("statDrain", expQ.size(), 0);
      checkOutput("statAckPulses", ackCount, 1);

      // Reset, then 257 frames so the sequence byte wraps.
      $display("[TB] sequence wrap");
      rst_ = 1'b0;
      tick();
      checkOutput("rst2Drop", drop_cnt, 0);
      checkOutput("rst2Level", fifo_level, 0);
      rst_ = 1'b1;
      tick();
      for (int f = 0; f < 257; f++) begin
         pushFrame(8'(f), 8'(f * 4), 8'(f * 4 + 1), 8'(f * 4 + 2), 8'(f * 4 + 3));
         for (int k = 0; k < 4; k++) applyStimulus(8'(f * 4 + k));
         waitDrain(30, "wrapDrain");
      end

      // Asynchronous reset in the middle of DATA.
      $display("[TB] async reset mid-frame");
      pushFrame(8'h01, 8'h90, 8'h91, 8'h92, 8'h93);
      applyStimulus(8'h90);
      applyStimulus(8'h91);
      applyStimulus(8'h92);
      applyStimulus(8'h93);
      checkOutput("preRstData", tx_data, 8'h90);
      #2;
      rst_ = 1'b0;
      #1;
      expQ.delete();
      checkOutput("asyncValid", tx_valid, 0);
      checkOutput("asyncData", tx_data, 0);
      checkOutput("asyncLevel", fifo_level, 0);
      checkOutput("asyncAck", stat_ack, 0);
      tick();
      rst_ = 1'b1;
      repeat (6) tick();
      checkOutput("postRstIdle", tx_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
